// File: rtl/branch_predictor_pkg.sv
// ----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared types for the fetch-side branch direction predictor.
//   ctr_t   : 2-bit saturating counter (SNT/WNT/WT/ST encodings)
//   state_t : predictor FSM state (table initialisation vs. normal running)
// ----------------------------------------------------------------------------
package branch_predictor_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// ----------------------------------------------------------------------------
// sat_ctr2
// Next-state function of one 2-bit saturating direction counter.
// Ports:
//   i_ctr   : current counter value
//   i_taken : resolved branch direction
//   o_ctr   : counter value after one training step
// ----------------------------------------------------------------------------
module sat_ctr2
    import branch_predictor_pkg::*;
(
    input  ctr_t i_ctr,
    input  logic i_taken,
    output ctr_t o_ctr
);

    // Step one position towards the resolved direction, sticking at both ends.
    always_comb begin
        o_ctr = i_ctr;
        case (i_ctr)
            CTR_SNT: o_ctr = i_taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: o_ctr = i_taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  o_ctr = i_taken ? CTR_ST  : CTR_WNT;
            default: o_ctr = i_taken ? CTR_ST  : CTR_WT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
// Table of 2-bit saturating counters indexed by pc[IDX_W+1:2]. Fetch lookups
// are answered one cycle later; execute-stage resolutions train the table,
// flag mispredictions and drive two saturating performance counters.
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_stall                 : holds the lookup output registers
//   i_lk_valid, i_lk_pc     : fetch lookup request
//   o_pred_valid/_taken     : registered lookup response
//   i_upd_valid/_pc/_taken  : resolved branch
//   i_upd_pred              : prediction that was used for that branch
//   o_mispredict            : registered misprediction flag
//   o_ready                 : table initialised, updates accepted
//   i_cnt_clr               : clears both performance counters
//   o_branch_count          : resolved branches since reset/clear
//   o_mispredict_count      : mispredicted branches since reset/clear
// ----------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int   IDX_W    = 6,
    parameter ctr_t INIT_CTR = 2'b01
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_lk_valid,
    input  logic [31:0] i_lk_pc,
    output logic        o_pred_valid,
    output logic        o_pred_taken,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic        i_upd_pred,
    output logic        o_mispredict,
    output logic        o_ready,
    input  logic        i_cnt_clr,
    output logic [31:0] o_branch_count,
    output logic [31:0] o_mispredict_count
);

    localparam int ENTRIES = 2 ** IDX_W;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_init_idx;
    ctr_t               r_table [ENTRIES];

    logic               r_pred_valid;
    logic               r_pred_taken;
    logic               r_mispredict;
    logic [31:0]        r_branch_count;
    logic [31:0]        r_mispredict_count;

    logic [IDX_W-1:0]   w_lk_idx;
    logic [IDX_W-1:0]   w_upd_idx;
    logic               w_upd_accept;
    logic               w_upd_miss;
    ctr_t               w_upd_ctr_next;
    ctr_t               w_lk_ctr;
    logic               w_wr_en;
    logic [IDX_W-1:0]   w_wr_idx;
    ctr_t               w_wr_data;
    logic               w_unused;

    assign w_lk_idx     = i_lk_pc[IDX_W+1:2];
    assign w_upd_idx    = i_upd_pc[IDX_W+1:2];
    assign w_upd_accept = i_upd_valid && (r_state == ST_RUN);
    assign w_upd_miss   = i_upd_taken ^ i_upd_pred;

    assign w_unused = ^{i_lk_pc[31:IDX_W+2], i_lk_pc[1:0],
                        i_upd_pc[31:IDX_W+2], i_upd_pc[1:0]};

    sat_ctr2 u_upd_ctr (
        .i_ctr   (r_table[w_upd_idx]),
        .i_taken (i_upd_taken),
        .o_ctr   (w_upd_ctr_next)
    );

    // Write-first bypass: a lookup hitting the entry being trained this
    // cycle must see the trained value, not the stale table contents.
    assign w_lk_ctr = (w_upd_accept && (w_upd_idx == w_lk_idx))
                      ? w_upd_ctr_next : r_table[w_lk_idx];

    // Single table write port: the init sweep owns it until RUN, then the
    // execute-stage update does.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = w_upd_idx;
        w_wr_data = w_upd_ctr_next;
        if (r_state == ST_INIT) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_init_idx;
            w_wr_data = INIT_CTR;
        end else if (w_upd_accept) begin
            w_wr_en   = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr_en) begin
            r_table[w_wr_idx] <= w_wr_data;
        end
    end

    // INIT leaves for RUN on the cycle that writes the last entry.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: if (r_init_idx == IDX_W'(ENTRIES - 1)) w_state_next = ST_RUN;
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_INIT;
            r_init_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_INIT) begin
                r_init_idx <= r_init_idx + 1'b1;
            end
        end
    end

    // Lookup response; during INIT the table is not yet valid so the
    // prediction is forced not-taken.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
        end else if (!i_stall) begin
            r_pred_valid <= i_lk_valid;
            r_pred_taken <= i_lk_valid && (r_state == ST_RUN) && w_lk_ctr[1];
        end
    end

    // Misprediction flag and saturating counters; a clear beats a
    // coincident update for counting purposes only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mispredict       <= 1'b0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_mispredict <= w_upd_accept && w_upd_miss;
            if (i_cnt_clr) begin
                r_branch_count     <= '0;
                r_mispredict_count <= '0;
            end else if (w_upd_accept) begin
                if (r_branch_count != 32'hFFFF_FFFF) begin
                    r_branch_count <= r_branch_count + 32'd1;
                end
                if (w_upd_miss && (r_mispredict_count != 32'hFFFF_FFFF)) begin
                    r_mispredict_count <= r_mispredict_count + 32'd1;
                end
            end
        end
    end

    assign o_pred_valid       = r_pred_valid;
    assign o_pred_taken       = r_pred_taken;
    assign o_mispredict       = r_mispredict;
    assign o_ready            = (r_state == ST_RUN);
    assign o_branch_count     = r_branch_count;
    assign o_mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor
// Drives directed scenarios and random traffic into branch_predictor and
// compares every output, every cycle, against a behavioural model that keeps
// the counter table as plain integers.
// ----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int ENTRIES  = 64;
    localparam int INIT_VAL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        lkValid = 1'b0;
    logic [31:0] lkPc = '0;
    logic        updValid = 1'b0;
    logic [31:0] updPc = '0;
    logic        updTaken = 1'b0;
    logic        updPred = 1'b0;
    logic        cntClr = 1'b0;
    logic        predValid;
    logic        predTaken;
    logic        mispredict;
    logic        ready;
    logic [31:0] branchCount;
    logic [31:0] mispredictCount;

    int checks = 0;
    int errors = 0;

    int          mTable [ENTRIES];
    int          mInitIdx = 0;
    bit          mReady = 0;
    bit          mPv = 0;
    bit          mPt = 0;
    bit          mMis = 0;
    logic [31:0] mBc = '0;
    logic [31:0] mMc = '0;

    branch_predictor #(.IDX_W(6), .INIT_CTR(2'b01)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_stall            (stall),
        .i_lk_valid         (lkValid),
        .i_lk_pc            (lkPc),
        .o_pred_valid       (predValid),
        .o_pred_taken       (predTaken),
        .i_upd_valid        (updValid),
        .i_upd_pc           (updPc),
        .i_upd_taken        (updTaken),
        .i_upd_pred         (updPred),
        .o_mispredict       (mispredict),
        .o_ready            (ready),
        .i_cnt_clr          (cntClr),
        .o_branch_count     (branchCount),
        .o_mispredict_count (mispredictCount)
    );

    always #5 clk = ~clk;

    // Safety net so a wedged run still ends with a verdict.
    initial begin
        #500000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    function automatic int pcIndex(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    // One clock edge of the predictor described in terms of the rules:
    // init sweep, saturating training, lookup after training, counters.
    task automatic modelStep(input logic r, s, lv, input logic [31:0] lp,
                             input logic uv, input logic [31:0] up,
                             input logic ut, upr, cc);
        bit wasReady;
        bit accept;
        int i;
        if (r) begin
            mReady = 0; mInitIdx = 0; mPv = 0; mPt = 0; mMis = 0;
            mBc = '0; mMc = '0;
        end else begin
            wasReady = mReady;
            accept   = wasReady && uv;
            if (!wasReady) begin
                mTable[mInitIdx] = INIT_VAL;
                mInitIdx++;
                if (mInitIdx == ENTRIES) mReady = 1;
            end else if (uv) begin
                i = pcIndex(up);
                if (ut) mTable[i] = (mTable[i] == 3) ? 3 : mTable[i] + 1;
                else    mTable[i] = (mTable[i] == 0) ? 0 : mTable[i] - 1;
            end
            if (!s) begin
                mPv = lv;
                mPt = wasReady && lv && (mTable[pcIndex(lp)] >= 2);
            end
            mMis = accept && (ut != upr);
            if (cc) begin
                mBc = '0; mMc = '0;
            end else if (accept) begin
                if (mBc != 32'hFFFF_FFFF) mBc = mBc + 1;
                if ((ut != upr) && (mMc != 32'hFFFF_FFFF)) mMc = mMc + 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, s, lv, input logic [31:0] lp,
                                 input logic uv, input logic [31:0] up,
                                 input logic ut, upr, cc);
        @(negedge clk);
        rst = r; stall = s; lkValid = lv; lkPc = lp;
        updValid = uv; updPc = up; updTaken = ut; updPred = upr; cntClr = cc;
        @(posedge clk);
        modelStep(r, s, lv, lp, uv, up, ut, upr, cc);
        #1;
        checkOutput("predValid", 32'(predValid), 32'(mPv));
        checkOutput("predTaken", 32'(predTaken), 32'(mPt));
        checkOutput("mispredict", 32'(mispredict), 32'(mMis));
        checkOutput("ready", 32'(ready), 32'(mReady));
        checkOutput("branchCount", branchCount, mBc);
        checkOutput("mispredictCount", mispredictCount, mMc);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        applyStimulus(0, 0, 1, pc, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic p);
        applyStimulus(0, 0, 0, 32'h0, 1, pc, t, p, 0);
    endtask

    initial begin
        int pulses;
        logic [31:0] rp;
        logic [31:0] ru;

        // Reset, then the 64-cycle init sweep with a lookup and an update
        // slipped in while the table is still being written.
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < ENTRIES; i++) begin
            if (i == 10) begin
                lookup(32'h100);
                checkOutput("initLookupTaken", 32'(predTaken), 32'd0);
                checkOutput("initLookupValid", 32'(predValid), 32'd1);
            end else if (i == 20) begin
                update(32'h100, 1, 0);
            end else begin
                idle();
            end
            checkOutput("readyTiming", 32'(ready), (i == ENTRIES - 1) ? 32'd1 : 32'd0);
        end
        checkOutput("initNoCount", branchCount, 32'd0);

        // Training on pc 0x100.
        update(32'h100, 1, 0);
        update(32'h100, 1, 0);
        lookup(32'h100);
        checkOutput("trainTaken", 32'(predTaken), 32'd1);
        update(32'h100, 0, 1);
        update(32'h100, 0, 1);
        lookup(32'h100);
        checkOutput("trainNotTaken", 32'(predTaken), 32'd0);
        for (int i = 0; i < 3; i++) update(32'h100, 0, 0);
        update(32'h100, 1, 0);
        lookup(32'h100);
        checkOutput("trainSaturate", 32'(predTaken), 32'd0);

        // Aliased lookup 0x200 in the same cycle as a taken update of 0x100.
        applyStimulus(0, 0, 1, 32'h200, 1, 32'h100, 1, 0, 0);
        checkOutput("bypassTaken", 32'(predTaken), 32'd1);

        // Stall holds a taken prediction while lk_pc points at a not-taken entry.
        update(32'h104, 1, 0);
        update(32'h104, 1, 0);
        lookup(32'h104);
        checkOutput("preStallTaken", 32'(predTaken), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 32'h108, 0, 32'h0, 0, 0, 0);
            checkOutput("stallHold", 32'(predTaken), 32'd1);
        end
        lookup(32'h108);
        checkOutput("postStall", 32'(predTaken), 32'd0);

        // Performance counters.
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        pulses = 0;
        update(32'h300, 1, 1); pulses += int'(mispredict);
        update(32'h300, 1, 0); pulses += int'(mispredict);
        update(32'h300, 0, 0); pulses += int'(mispredict);
        update(32'h300, 0, 1); pulses += int'(mispredict);
        update(32'h300, 1, 1); pulses += int'(mispredict);
        checkOutput("branchCount5", branchCount, 32'd5);
        checkOutput("mispredictCount2", mispredictCount, 32'd2);
        checkOutput("mispredictPulses", 32'(pulses), 32'd2);
        applyStimulus(0, 0, 0, 32'h0, 1, 32'h300, 1, 0, 1);
        checkOutput("clrBranch", branchCount, 32'd0);
        checkOutput("clrMispredict", mispredictCount, 32'd0);

        // Saturation at the top of the branch counter.
        @(negedge clk);
        force dut.r_branch_count = 32'hFFFF_FFFF;
        mBc = 32'hFFFF_FFFF;
        idle();
        release dut.r_branch_count;
        update(32'h300, 1, 1);
        checkOutput("branchSaturate", branchCount, 32'hFFFF_FFFF);

        // Random traffic over a handful of indices with aliased upper bits.
        for (int n = 0; n < 400; n++) begin
            rp = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3);
            ru = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3);
            applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
                          $urandom_range(0, 1) == 1, rp, $urandom_range(0, 1) == 1, ru,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 49) == 0));
        end

        // Mid-operation reset: everything back to idle values, table re-swept.
        update(32'h104, 1, 0);
        applyStimulus(1, 0, 1, 32'h104, 1, 32'h104, 1, 0, 0);
        checkOutput("rstReady", 32'(ready), 32'd0);
        checkOutput("rstPredValid", 32'(predValid), 32'd0);
        checkOutput("rstMispredict", 32'(mispredict), 32'd0);
        checkOutput("rstBranchCount", branchCount, 32'd0);
        for (int i = 0; i < ENTRIES; i++) idle();
        checkOutput("rstReadyAgain", 32'(ready), 32'd1);
        for (int i = 0; i < ENTRIES; i++) begin
            lookup(32'(i) << 2);
            checkOutput("sweepNotTaken", 32'(predTaken), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
